// File: rtl/sram_req_ctrl.sv
// Request front-end for a single-port SRAM macro: issues RW0 accesses on a valid/ready
// handshake, captures read data in the one cycle it is valid, and returns in-order responses.
module sram_req_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = DATA_W / 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              vld_p1;
  logic              wr_p1;
  logic [DATA_W-1:0] fifo_data  [RESP_DEPTH];
  logic              fifo_write [RESP_DEPTH];
  logic [CNT_W:0]    credit_used;
  logic              fire;
  logic              push;
  logic              pop;
  logic              empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The inflight slot holds a credit so a capture can never find the FIFO full.
  assign credit_used = {1'b0, count} + (CNT_W + 1)'(vld_p1);
  assign req_ready   = reset_n && (credit_used < (CNT_W + 1)'(RESP_DEPTH));
  assign fire        = req_valid && req_ready;

  assign sram_en    = fire;
  assign sram_wmode = fire && req_write;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_data;
  assign sram_wmask = req_write ? req_mask : '0;

  assign empty      = (count == '0);
  assign resp_valid = reset_n && !empty;
  assign resp_write = !empty && fifo_write[rd_ptr];
  assign resp_data  = empty ? '0 : fifo_data[rd_ptr];

  assign push = vld_p1;
  assign pop  = resp_valid && resp_ready;

  // ---- p0 -> p1: access issued to the macro, await its single valid rdata cycle ----
  always_ff @(posedge clock) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= fire;
  end

  always_ff @(posedge clock) begin
    wr_p1 <= req_write;
  end

  // ---- p1 -> FIFO: capture rdata (or a write ack) in request order ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr]  <= wr_p1 ? '0 : sram_rdata;
      fifo_write[wr_ptr] <= wr_p1;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM macro plus a fire-ordered response scoreboard.
module tb_sram_req_ctrl;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = 4;
  localparam int RESP_DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_write;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clock = ~clock;

  sram_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_data(resp_data),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural macro: registered read address, rdata valid only the cycle after a read.
  logic [DATA_W-1:0] sram_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] rd_q;
  logic              rd_v;
  logic [DATA_W-1:0] garbage;

  always @(posedge clock) begin
    garbage <= $urandom;
    rd_v    <= sram_en && !sram_wmode;
    if (sram_en && !sram_wmode) rd_q <= sram_addr;
    if (sram_en && sram_wmode)
      for (int b = 0; b < MASK_W; b++)
        if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  assign sram_rdata = rd_v ? sram_mem[rd_q] : garbage;

  // Reference model: word memory plus queue of responses owed, in fire order.
  typedef struct {
    logic              w;
    logic [DATA_W-1:0] d;
    int                cyc;
  } exp_t;

  exp_t              exp_q [$];
  logic [DATA_W-1:0] ref_mem [int];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                n_fire   = 0;
  int                n_resp   = 0;
  logic              fired    = 1'b0;
  logic              post_rst = 1'b0;
  logic [DATA_W-1:0] last_rd  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic step();
    exp_t              e;
    logic              exp_valid;
    logic [DATA_W-1:0] word;
    #1;
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_sram_en", sram_en, 0);
      exp_q.delete();
      post_rst = 1'b1;
      fired    = 1'b0;
    end else begin
      chk("req_ready", req_ready, exp_q.size() < RESP_DEPTH);
      fired = req_valid && req_ready;
      chk("sram_en", sram_en, fired);
      if (fired) begin
        chk("sram_addr", sram_addr, req_addr);
        chk("sram_wmode", sram_wmode, req_write);
        chk("sram_wmask", sram_wmask, req_write ? req_mask : 4'h0);
        chk("sram_wdata", sram_wdata, req_data);
      end
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
      chk("resp_valid", resp_valid, exp_valid);
      if (post_rst && exp_q.size() == 0) begin
        chk("idle_resp_write", resp_write, 0);
        chk("idle_resp_data", resp_data, 0);
      end
      if (resp_valid && exp_valid) begin
        chk("resp_write", resp_write, exp_q[0].w);
        chk("resp_data", resp_data, exp_q[0].d);
        if (resp_ready) begin
          e = exp_q.pop_front();
          if (!e.w) last_rd = e.d;
          n_resp++;
        end
      end
      if (fired) begin
        if (req_write) begin
          word = ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : '0;
          for (int b = 0; b < MASK_W; b++)
            if (req_mask[b]) word[8*b +: 8] = req_data[8*b +: 8];
          ref_mem[int'(req_addr)] = word;
          e.w = 1'b1;
          e.d = '0;
        end else begin
          e.w = 1'b0;
          e.d = ref_mem[int'(req_addr)];
        end
        e.cyc = cyc;
        exp_q.push_back(e);
        post_rst = 1'b0;
        n_fire++;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_mask  = m;
    req_data  = d;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fired) break;
    end
    chk("issue_fired", fired, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    int r0;
    reset_n    = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = '0;
    req_mask   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    @(negedge clock);

    // Reset with a request offered, then idle.
    for (int i = 0; i < 3; i++) step();
    reset_n   = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Write then read the same word in consecutive cycles.
    issue(1'b1, 12'h005, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 12'h005, 4'h0, 32'h0);
    drain(10);
    chk("raw_data", last_rd, 32'hDEADBEEF);

    // Zero-mask write is issued and acknowledged, memory unchanged.
    issue(1'b1, 12'h005, 4'h0, 32'h01234567);
    issue(1'b0, 12'h005, 4'h0, 32'h0);
    drain(10);
    chk("mask0_data", last_rd, 32'hDEADBEEF);

    // Partial-byte overwrite.
    issue(1'b1, 12'h010, 4'hF, 32'h12345678);
    issue(1'b1, 12'h010, 4'h5, 32'hAABBCCDD);
    issue(1'b0, 12'h010, 4'h0, 32'h0);
    drain(10);
    chk("pmask_data", last_rd, 32'h12BB56DD);

    for (int a = 0; a < 16; a++) issue(1'b1, 12'h100 + 12'(a), 4'hF, $urandom);
    drain(10);

    // Backpressure: only RESP_DEPTH requests may be outstanding.
    resp_ready = 1'b0;
    r0         = n_resp;
    k          = 0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 12'h100 + 12'(k);
      step();
      if (fired) k++;
    end
    chk("bp_fires", k, 4);
    chk("bp_stalled", req_ready, 0);
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && k < 6; i++) begin
      req_addr = 12'h100 + 12'(k);
      step();
      if (fired) k++;
    end
    req_valid = 1'b0;
    chk("bp_all_fired", k, 6);
    drain(20);
    chk("bp_resp_count", n_resp - r0, 6);

    // Streaming reads at one per cycle.
    for (int a = 0; a < 100; a++) issue(1'b1, 12'(a), 4'hF, 32'(a) ^ 32'hA5A5A5A5);
    drain(10);
    k         = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 100; i++) begin
      req_addr = 12'(k);
      step();
      if (fired) k++;
    end
    req_valid = 1'b0;
    chk("stream_no_bubble", k, 100);
    drain(10);
    chk("stream_last", last_rd, 32'd99 ^ 32'hA5A5A5A5);

    // Reset with two responses queued and one in flight.
    resp_ready = 1'b0;
    issue(1'b0, 12'h100, 4'h0, 32'h0);
    issue(1'b0, 12'h101, 4'h0, 32'h0);
    issue(1'b0, 12'h102, 4'h0, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    resp_ready = 1'b1;
    r0         = n_resp;
    issue(1'b0, 12'h103, 4'h0, 32'h0);
    drain(10);
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_resp_count", n_resp - r0, 1);
    chk("post_rst_data", last_rd, sram_mem[12'h103]);

    // Random traffic over a preloaded window with random backpressure.
    for (int i = 0; i < 300; i++) begin
      if (!req_valid || fired) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 12'h100 + 12'($urandom_range(0, 15));
        req_mask  = 4'($urandom);
        req_data  = $urandom;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
Request front-end that sits directly upstream of a single-port behavioural SRAM macro (RW0 port: addr, en, wmode, byte wmask, wdata, registered-address rdata). It accepts read/write requests over a valid/ready handshake and drives the SRAM port. It captures read data in the only cycle the macro guarantees it, and returns in-order responses through a credit-protected response FIFO with valid/ready backpressure. One instance per SRAM; the system SRAM uses a 12-bit address and each test-harness bank uses an 11-bit address.

Parameters:
ADDR_W, 12, SRAM word-address width; must match the macro address port.
DATA_W, 32, data width; must be a multiple of 8.
MASK_W, DATA_W/8, byte-lane mask width.
RESP_DEPTH, 4, response FIFO entries; minimum 2; 3 or more gives 1 request/cycle throughput.

Ports:
clock  in  1  single clock; drives this block and the SRAM RW0_clk.
reset_n  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when high together with req_valid (fire).
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_mask  in  MASK_W  byte write enables; ignored on reads.
req_data  in  DATA_W  write data.
resp_valid  out  1  response available at FIFO head.
resp_ready  in  1  consumer accepts response.
resp_write  out  1  1 = write acknowledge, 0 = read data.
resp_data  out  DATA_W  read data; 0 for write acks.
sram_addr  out  ADDR_W  to RW0_addr.
sram_en  out  1  to RW0_en.
sram_wmode  out  1  to RW0_wmode.
sram_wmask  out  MASK_W  to RW0_wmask.
sram_wdata  out  DATA_W  to RW0_wdata.
sram_rdata  in  DATA_W  from RW0_rdata.

Behaviour:
- Reset (reset_n low at a clock edge): FIFO count, rd/wr pointers and the inflight flag all clear. Outputs while reset_n is low: req_ready=0, resp_valid=0, sram_en=0. Outputs out of reset are decoded from these cleared registers: resp_write=0, resp_data=0.
- Reset mid-operation discards in-flight and queued responses. No SRAM access is issued while reset_n is low.
- Credit rule: req_ready = reset_n && (count + inflight < RESP_DEPTH). It depends on registers only; there is no combinational path from resp_ready or req_valid.
- SRAM drive is combinational in the fire cycle T:
  - sram_en = fire; sram_wmode = fire && req_write.
  - sram_addr = req_addr; sram_wdata = req_data.
  - sram_wmask = req_write ? req_mask : 0.
- Inflight stage: at edge T, inflight <= fire and inflight_write <= req_write.
- Capture in cycle T+1 when inflight=1:
  - Read: push {write=0, data=sram_rdata} into the FIFO at edge T+1. sram_rdata is sampled only in this cycle; the macro may return garbage in any other cycle.
  - Write: push {write=1, data=0} at the same point, which keeps responses strictly in request order.
- Latency: resp_valid rises in cycle T+2 for the request fired in T. There is no bypass of the FIFO.
- FIFO behaviour:
  - Head drives resp_* directly; pop on resp_valid && resp_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
  - Overflow cannot occur: the credit rule counts the inflight slot.
- Write with req_mask=0 is still issued (sram_en=1, wmask=0, memory unchanged) and still acknowledged.
- Read-after-write to the same address in consecutive cycles returns the new data: the write commits at edge T and the read is issued in T+1.
- Back-to-back reads to different addresses each capture their own data. The macro holds each read address for exactly one cycle of valid output.
- resp_* hold stable while resp_valid=1 and resp_ready=0.

Test Plan:
1. Reset then idle → req_ready=1 in the first cycle after reset_n rises; resp_valid=0; sram_en=0 throughout.
2. Write addr 0x005, data 0xDEADBEEF, mask 0xF, then read 0x005 the next cycle → responses in order: {write=1, data=0}, then {write=0, data=0xDEADBEEF}. The read response has resp_valid high 2 cycles after its fire.
3. Write 0x12345678 to 0x010 with mask 0xF, then write 0xAABBCCDD to 0x010 with mask 0x5, then read 0x010 → read data 0x12BB56DD.
4. resp_ready held 0 and 6 reads offered back-to-back with RESP_DEPTH=4 → exactly 4 fire, then req_ready=0. Raise resp_ready → 4 responses drain in address order and issuing resumes. No response is lost or duplicated.
5. resp_ready=1 and a continuous stream of 100 reads to addresses 0..99 preloaded with addr^0xA5A5A5A5 → one fire per cycle with no bubbles; every response matches its address.
6. Assert reset_n low for 1 cycle with 2 responses queued and 1 inflight → resp_valid=0 after reset. A new read then returns correct data with the normal 2-cycle latency, and no stale responses appear.
